uart_rx_8n1: RTL and testbench

Serial receiver for 8N1 UART frames: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high), idle-high line. It sits directly downstream of the transmitter on the serial link and converts the line back into bytes for the logic that consumes received data. The block oversamples the line and resynchronises to every start edge. It reports each byte with a one-cycle `valid` strobe and reports bad stop bits as `frame_err`.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_8n1_if.sv | 28 ++
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx_8n1.sv | 119 +++++++++++
 tb/tb_uart_rx_8n1.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the 8N1 UART receive path.
// Imported by the synchroniser, the interface and the receiver top.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

   localparam logic UART_HIGH = 1'b1;
   localparam logic UART_LOW  = 1'b0;

   localparam int DEF_OVERSAMPLE = 16;
   localparam int DATA_BITS      = 8;
   localparam int STOP_BITS      = 1;

endpackage

// File: rtl/uart_rx_8n1_if.sv
// Serial line in, received byte and status strobes out.
// The receiver takes the master side; the byte consumer the slave side.
interface uart_rx_8n1_if;
   import uart_pkg::*;

   logic                 uart_rx;
   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 frame_err;
   logic                 busy;

   modport master (
      input  uart_rx,
      output data,
      output valid,
      output frame_err,
      output busy
   );

   modport slave (
      output uart_rx,
      input  data,
      input  valid,
      input  frame_err,
      input  busy
   );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Resets to the idle (high) level so reset never looks like a start bit.
module uart_rx_sync
   import uart_pkg::*;
(
   input  logic baud_clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge baud_clk or posedge rst) begin
      if (rst) begin
         meta <= UART_HIGH;
         q    <= UART_HIGH;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_8n1.sv
// Oversampling 8N1 UART receiver: resyncs on each start edge,
// samples mid-bit, strobes valid on a good stop bit, frame_err otherwise.
module uart_rx_8n1
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
   input  logic          baud_clk,
   input  logic          rst,
   uart_rx_8n1_if.master bus
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam logic [CNT_W-1:0] HALF = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

   rx_state_t            state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [2:0]           idx, idx_n;
   logic [DATA_BITS-1:0] sh, sh_n;
   logic [DATA_BITS-1:0] data_q, data_n;
   logic                 valid_q, valid_n;
   logic                 ferr_q, ferr_n;
   logic                 rx_s;

   uart_rx_sync u_sync (
      .baud_clk (baud_clk),
      .rst      (rst),
      .d        (bus.uart_rx),
      .q        (rx_s)
   );

   always_ff @(posedge baud_clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         sh      <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         idx     <= idx_n;
         sh      <= sh_n;
         data_q  <= data_n;
         valid_q <= valid_n;
         ferr_q  <= ferr_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      sh_n    = sh;
      data_n  = data_q;
      valid_n = 1'b0;
      ferr_n  = 1'b0;
      unique case (state)
         IDLE: begin
            if (rx_s == UART_LOW) begin
               state_n = START;
               cnt_n   = '0;
            end
         end
         START: begin
            cnt_n = cnt + 1'b1;
            if (cnt == HALF) begin
               cnt_n = '0;
               if (rx_s == UART_LOW) begin
                  state_n = DATA;
                  idx_n   = '0;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         DATA: begin
            cnt_n = cnt + 1'b1;
            if (cnt == LAST) begin
               cnt_n = '0;
               sh_n  = {rx_s, sh[DATA_BITS-1:1]};
               idx_n = idx + 1'b1;
               if (idx == IDX_LAST) state_n = STOP;
            end
         end
         STOP: begin
            cnt_n = cnt + 1'b1;
            if (cnt == LAST) begin
               cnt_n = '0;
               if (rx_s == UART_HIGH) begin
                  data_n  = sh;
                  valid_n = 1'b1;
                  state_n = IDLE;
               end else begin
                  ferr_n  = 1'b1;
                  state_n = BREAK;
               end
            end
         end
         // Held-low line must go high before another start is accepted
         BREAK: begin
            if (rx_s == UART_HIGH) state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.data      = data_q;
   assign bus.valid     = valid_q;
   assign bus.frame_err = ferr_q;
   assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed self-checking bench for uart_rx_8n1 at OVERSAMPLE=16.
// Frames are driven on negedges; outputs are sampled on negedges.
module tb_uart_rx_8n1;

   logic baud_clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   nerr = 0;
   int   nchk = 0;

   int          vq_cyc[$];
   logic [7:0]  vq_dat[$];
   int          fq_cyc[$];
   int          both = 0;
   int          brun = 0;
   int          bmax = 0;

   uart_rx_8n1_if bus ();

   uart_rx_8n1 #(.OVERSAMPLE(16)) dut (
      .baud_clk (baud_clk),
      .rst      (rst),
      .bus      (bus.master)
   );

   always #5 baud_clk = ~baud_clk;

   always @(posedge baud_clk) cyc = cyc + 1;

   always @(negedge baud_clk) begin
      if (bus.valid === 1'b1) begin
         vq_cyc.push_back(cyc);
         vq_dat.push_back(bus.data);
      end
      if (bus.frame_err === 1'b1) fq_cyc.push_back(cyc);
      if (bus.valid === 1'b1 && bus.frame_err === 1'b1) both++;
      if (bus.busy === 1'b1) begin
         brun++;
         if (brun > bmax) bmax = brun;
      end else begin
         brun = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int qc(input int i);
      return (i < vq_cyc.size()) ? vq_cyc[i] : -1;
   endfunction

   function automatic logic [7:0] qd(input int i);
      return (i < vq_dat.size()) ? vq_dat[i] : 8'hxx;
   endfunction

   function automatic int fc(input int i);
      return (i < fq_cyc.size()) ? fq_cyc[i] : -1;
   endfunction

   task automatic clear_mon();
      vq_cyc.delete();
      vq_dat.delete();
      fq_cyc.delete();
      bmax = 0;
   endtask

   // Called on a negedge; scale is the bit length in per-mille of nominal
   task automatic send_frame(input logic [7:0] b, input logic stop,
                             input int scale, output int t0);
      logic [9:0] bits;
      int b0, b1;
      bits = {stop, b, 1'b0};
      t0 = cyc;
      for (int i = 0; i < 10; i++) begin
         bus.uart_rx = bits[i];
         b0 = (i * 16 * scale + 500) / 1000;
         b1 = ((i + 1) * 16 * scale + 500) / 1000;
         repeat (b1 - b0) @(negedge baud_clk);
      end
   endtask

   initial begin
      int t0, tx;
      bus.uart_rx = 1'b1;
      rst = 1'b1;
      repeat (4) @(negedge baud_clk);
      check("rst_data", 32'(bus.data), 32'h00);
      check("rst_valid", 32'(bus.valid), 32'h0);
      check("rst_ferr", 32'(bus.frame_err), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      rst = 1'b0;
      repeat (10) @(negedge baud_clk);

      // single frame
      clear_mon();
      send_frame(8'hA5, 1'b1, 1000, t0);
      repeat (20) @(negedge baud_clk);
      check("a5_count", 32'(vq_cyc.size()), 32'd1);
      check("a5_time", 32'(qc(0)), 32'(t0 + 155));
      check("a5_data", 32'(qd(0)), 32'hA5);
      check("a5_ferr", 32'(fq_cyc.size()), 32'd0);
      check("a5_hold", 32'(bus.data), 32'hA5);

      // back-to-back frames
      clear_mon();
      send_frame(8'h00, 1'b1, 1000, t0);
      send_frame(8'hFF, 1'b1, 1000, tx);
      send_frame(8'h3C, 1'b1, 1000, tx);
      repeat (20) @(negedge baud_clk);
      check("b2b_count", 32'(vq_cyc.size()), 32'd3);
      check("b2b_t0", 32'(qc(0)), 32'(t0 + 155));
      check("b2b_t1", 32'(qc(1)), 32'(t0 + 315));
      check("b2b_t2", 32'(qc(2)), 32'(t0 + 475));
      check("b2b_d0", 32'(qd(0)), 32'h00);
      check("b2b_d1", 32'(qd(1)), 32'hFF);
      check("b2b_d2", 32'(qd(2)), 32'h3C);
      check("b2b_ferr", 32'(fq_cyc.size()), 32'd0);

      // start glitch
      clear_mon();
      bus.uart_rx = 1'b0;
      repeat (4) @(negedge baud_clk);
      bus.uart_rx = 1'b1;
      repeat (40) @(negedge baud_clk);
      check("gl_valid", 32'(vq_cyc.size()), 32'd0);
      check("gl_busy_max", 32'(bmax <= 9), 32'd1);
      check("gl_busy_seen", 32'(bmax > 0), 32'd1);
      check("gl_idle", 32'(bus.busy), 32'h0);

      // bad stop bit then long break
      clear_mon();
      send_frame(8'h55, 1'b0, 1000, t0);
      repeat (640) @(negedge baud_clk);
      check("fe_busy_brk", 32'(bus.busy), 32'h1);
      bus.uart_rx = 1'b1;
      repeat (30) @(negedge baud_clk);
      check("fe_count", 32'(fq_cyc.size()), 32'd1);
      check("fe_time", 32'(fc(0)), 32'(t0 + 155));
      check("fe_valid", 32'(vq_cyc.size()), 32'd0);
      check("fe_data", 32'(bus.data), 32'h3C);
      check("fe_idle", 32'(bus.busy), 32'h0);

      // reset mid-frame, then clean frame
      clear_mon();
      fork
         send_frame(8'h81, 1'b1, 1000, tx);
         begin
            repeat (88) @(negedge baud_clk);
            rst = 1'b1;
            #1;
            check("ab_busy", 32'(bus.busy), 32'h0);
            check("ab_data", 32'(bus.data), 32'h00);
            repeat (48) @(negedge baud_clk);
            rst = 1'b0;
         end
      join
      repeat (40) @(negedge baud_clk);
      check("ab_none", 32'(vq_cyc.size() + fq_cyc.size()), 32'd0);
      send_frame(8'h7E, 1'b1, 1000, t0);
      repeat (20) @(negedge baud_clk);
      check("7e_count", 32'(vq_cyc.size()), 32'd1);
      check("7e_time", 32'(qc(0)), 32'(t0 + 155));
      check("7e_data", 32'(qd(0)), 32'h7E);

      // baud skew
      clear_mon();
      send_frame(8'hC3, 1'b1, 1030, tx);
      repeat (20) @(negedge baud_clk);
      send_frame(8'hC3, 1'b1, 970, tx);
      repeat (20) @(negedge baud_clk);
      check("sk_count", 32'(vq_cyc.size()), 32'd2);
      check("sk_slow", 32'(qd(0)), 32'hC3);
      check("sk_fast", 32'(qd(1)), 32'hC3);
      check("sk_ferr", 32'(fq_cyc.size()), 32'd0);

      check("never_both", 32'(both), 32'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
